// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg : shared types, constants and helpers for the TDM demultiplexer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tdm_pkg;

  localparam int NCH_MIN = 2;
  localparam int NCH_MAX = 16;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Minimum bits needed to index `value` distinct items (at least 1 for value >= 2).
  function automatic int clog2(input int value);
    int bits;
    int v;
    bits = 0;
    v    = value - 1;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

  function automatic bit nch_legal(input int n);
    return (n >= NCH_MIN) && (n <= NCH_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdm_demux_if.sv
// ---------------------------------------------------------------------------
// tdm_demux_if : slot stream in, reassembled frame out
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tdm_demux_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);

  logic [WIDTH-1:0]     din;
  logic                 din_valid;
  logic                 frame_start;
  logic [NCH*WIDTH-1:0] ch_data;
  logic                 frame_valid;
  logic                 sync_err;
  logic [CNT_W-1:0]     frame_cnt;

  // Stream source / frame consumer side.
  modport master (
    output din,
    output din_valid,
    output frame_start,
    input  ch_data,
    input  frame_valid,
    input  sync_err,
    input  frame_cnt
  );

  // Demultiplexer side.
  modport slave (
    input  din,
    input  din_valid,
    input  frame_start,
    output ch_data,
    output frame_valid,
    output sync_err,
    output frame_cnt
  );

endinterface

`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
// ---------------------------------------------------------------------------
// tdm_slot_ctr : slot position counter with load-to-1, increment and clear
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int SW  = tdm_pkg::clog2(NCH)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          clr,
  input  wire logic          load1,
  input  wire logic          inc,
  output logic      [SW-1:0] slot,
  output logic               last
);

  logic [SW-1:0] slot_q;

  // Clear wins over load; load wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (clr) begin
      slot_q <= '0;
    end else if (load1) begin
      slot_q <= SW'(1);
    end else if (inc) begin
      slot_q <= slot_q + SW'(1);
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == SW'(NCH - 1));

endmodule

`default_nettype wire

// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux : reassembles NCH interleaved slot words into a parallel frame
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  tdm_demux_if.slave bus
);

  localparam int SW = clog2(NCH);

  if (!nch_legal(NCH)) begin : g_nch_range_check
    $error("tdm_demux: NCH out of legal range");
  end

  state_t               state_q;
  state_t               state_d;
  logic                 slot_clr;
  logic                 slot_load;
  logic                 slot_inc;
  logic [SW-1:0]        slot;
  logic                 slot_last;
  logic                 stage_en;
  logic [SW-1:0]        stage_idx;
  logic                 publish;
  logic                 err;
  logic [WIDTH-1:0]     stage_q [NCH-1];
  logic [NCH*WIDTH-1:0] frame_word;
  logic [NCH*WIDTH-1:0] ch_data_q;
  logic                 frame_valid_q;
  logic                 sync_err_q;
  logic [CNT_W-1:0]     frame_cnt_q;

  tdm_slot_ctr #(
    .NCH (NCH),
    .SW  (SW)
  ) u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (slot_clr),
    .load1 (slot_load),
    .inc   (slot_inc),
    .slot  (slot),
    .last  (slot_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_clr  = 1'b0;
    slot_load = 1'b0;
    slot_inc  = 1'b0;
    stage_en  = 1'b0;
    publish   = 1'b0;
    err       = 1'b0;
    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.frame_start) begin
            slot_load = 1'b1;
            stage_en  = 1'b1;
            state_d   = COLLECT;
          end else begin
            err = 1'b1;
          end
        end
        COLLECT: begin
          if (bus.frame_start) begin
            // Short frame: drop the partial and restart on this word.
            err       = 1'b1;
            slot_load = 1'b1;
            stage_en  = 1'b1;
          end else if (slot_last) begin
            publish  = 1'b1;
            slot_clr = 1'b1;
            state_d  = HUNT;
          end else begin
            slot_inc = 1'b1;
            stage_en = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign stage_idx = slot_load ? '0 : slot;

  for (genvar k = 0; k < NCH - 1; k++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q[k] <= '0;
      end else if (stage_en && (stage_idx == SW'(k))) begin
        stage_q[k] <= bus.din;
      end
    end
  end

  // The final slot bypasses staging so the frame publishes on its own edge.
  always_comb begin
    frame_word = '0;
    for (int k = 0; k < NCH - 1; k++) begin
      frame_word[k*WIDTH +: WIDTH] = stage_q[k];
    end
    frame_word[(NCH-1)*WIDTH +: WIDTH] = bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_valid_q <= publish;
      sync_err_q    <= err;
      if (publish) begin
        ch_data_q   <= frame_word;
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.ch_data     = ch_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux : directed and randomized checks of tdm_demux against a queue model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tdm_demux;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;

  tdm_demux_if #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) bus ();

  tdm_demux #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int fv_count = 0;
  int err_count = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a frame is a queue of words that must begin with frame_start.
  logic [WIDTH-1:0]     part[$];
  logic [NCH*WIDTH-1:0] m_ch;
  logic                 m_fv;
  logic                 m_err;
  int                   m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      part.delete();
      m_ch = '0; m_fv = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else begin
      m_fv = 1'b0;
      m_err = 1'b0;
      if (bus.din_valid) begin
        if (bus.frame_start) begin
          if (part.size() != 0) m_err = 1'b1;
          part.delete();
          part.push_back(bus.din);
        end else if (part.size() == 0) begin
          m_err = 1'b1;
        end else begin
          part.push_back(bus.din);
          if (part.size() == NCH) begin
            for (int i = 0; i < NCH; i++) m_ch[i*WIDTH +: WIDTH] = part[i];
            m_fv  = 1'b1;
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            part.delete();
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("ch_data", 64'(bus.ch_data), 64'(m_ch));
    chk("frame_valid", 64'(bus.frame_valid), 64'(m_fv));
    chk("sync_err", 64'(bus.sync_err), 64'(m_err));
    chk("frame_cnt", 64'(bus.frame_cnt), 64'(m_cnt));
    if (bus.frame_valid) fv_count++;
    if (bus.sync_err) err_count++;
  end

  task automatic send(input logic [WIDTH-1:0] w, input logic fs);
    @(negedge clk);
    bus.din         = w;
    bus.din_valid   = 1'b1;
    bus.frame_start = fs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.din_valid   = 1'b0;
      bus.frame_start = 1'($urandom_range(0, 1));
      bus.din         = WIDTH'($urandom);
    end
  endtask

  task automatic send_frame(input logic [NCH*WIDTH-1:0] f, input int max_gap);
    for (int k = 0; k < NCH; k++) begin
      send(f[k*WIDTH +: WIDTH], (k == 0));
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv0, ec0, r;
    rst_n = 1'b0;
    bus.din = '0; bus.din_valid = 1'b0; bus.frame_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ch", 64'(bus.ch_data), 64'h0);
    chk("rst_fv", 64'(bus.frame_valid), 64'h0);
    chk("rst_err", 64'(bus.sync_err), 64'h0);
    chk("rst_cnt", 64'(bus.frame_cnt), 64'h0);
    rst_n = 1'b1;

    // Clean frame
    send(8'h11, 1); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    idle(1);
    chk("clean_ch", 64'(bus.ch_data), 64'h44332211);
    chk("clean_model_ch", 64'(m_ch), 64'h44332211);
    chk("clean_fv", 64'(bus.frame_valid), 64'h1);
    chk("clean_cnt", 64'(bus.frame_cnt), 64'h1);
    chk("clean_err", 64'(bus.sync_err), 64'h0);

    // Gapped frame
    fv0 = fv_count;
    send(8'h11, 1); idle(3); send(8'h22, 0); idle(3);
    send(8'h33, 0); idle(3); send(8'h44, 0); idle(3);
    chk("gap_ch", 64'(bus.ch_data), 64'h44332211);
    chk("gap_fv_pulses", 64'(fv_count - fv0), 64'h1);
    chk("gap_cnt", 64'(bus.frame_cnt), 64'h2);

    // Short frame
    ec0 = err_count;
    send(8'hA0, 1); send(8'hA1, 0); send(8'hB0, 1);
    idle(1);
    chk("short_err", 64'(bus.sync_err), 64'h1);
    chk("short_hold_ch", 64'(bus.ch_data), 64'h44332211);
    send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0);
    chk("short_hold_ch2", 64'(bus.ch_data), 64'h44332211);
    idle(1);
    chk("short_ch", 64'(bus.ch_data), 64'hB3B2B1B0);
    chk("short_cnt", 64'(bus.frame_cnt), 64'h3);
    chk("short_err_count", 64'(err_count - ec0), 64'h1);

    // Unaligned start
    ec0 = err_count;
    send(8'h55, 0); send(8'h66, 0);
    send_frame(32'hC3C2C1C0, 0);
    idle(1);
    chk("unal_ch", 64'(bus.ch_data), 64'hC3C2C1C0);
    chk("unal_cnt", 64'(bus.frame_cnt), 64'h4);
    chk("unal_err_count", 64'(err_count - ec0), 64'h2);

    // Mid-frame reset
    send(8'hD0, 1); send(8'hD1, 0);
    pulse_reset();
    chk("mrst_ch", 64'(bus.ch_data), 64'h0);
    chk("mrst_cnt", 64'(bus.frame_cnt), 64'h0);
    chk("mrst_fv", 64'(bus.frame_valid), 64'h0);
    ec0 = err_count;
    send_frame(32'hE3E2E1E0, 0);
    idle(1);
    chk("mrst_ch2", 64'(bus.ch_data), 64'hE3E2E1E0);
    chk("mrst_cnt2", 64'(bus.frame_cnt), 64'h1);
    chk("mrst_err_count", 64'(err_count - ec0), 64'h0);

    // Counter wrap with 17 back-to-back frames
    pulse_reset();
    fv0 = fv_count;
    for (int f = 0; f < 17; f++) begin
      logic [NCH*WIDTH-1:0] fw;
      for (int k = 0; k < NCH; k++) fw[k*WIDTH +: WIDTH] = WIDTH'(f * 4 + k);
      send_frame(fw, 0);
    end
    idle(1);
    chk("wrap_cnt", 64'(bus.frame_cnt), 64'h1);
    chk("wrap_fv_pulses", 64'(fv_count - fv0), 64'd17);
    chk("wrap_ch", 64'(bus.ch_data), 64'h43424140);

    // Randomized traffic: mostly proper frames, some stray words and resets
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pulse_reset();
      end else if (r < 70) begin
        send_frame({$urandom}, $urandom_range(0, 2));
      end else if (r < 85) begin
        send(WIDTH'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        idle($urandom_range(1, 4));
      end
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
